// File: rtl/aes_pkg.sv
// Shared AES-256 types, round constants, FSM encoding and GF(2^8) helpers.
// Purely combinational helpers; no latency and no flow control live here.
package aes_pkg;

  typedef logic [127:0] block_t;
  typedef logic [3:0]   rkidx_t;

  localparam int AES256_NR       = 14;
  localparam int AES256_LAST_RND = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  // Inverse computed as x^254 by an addition chain, then the affine map; 0 maps to 0x63.
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(x3, x3);
    x12  = gf_mul(x12, x12);
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_256_round_ctrl_if.sv
// Block, round-key and status bundle between the CTR front end and the round controller.
// The ctr_load/ctr_seed pair exists only when AES_256_CTR_MODE_EN is defined.
interface aes_256_round_ctrl_if;
  import aes_pkg::*;

  logic   key_ready;
  rkidx_t rk_idx;
  block_t rk_data;
  logic   in_valid;
  logic   in_ready;
  block_t in_block;
  logic   out_valid;
  logic   out_ready;
  block_t out_block;
  logic   busy;
`ifdef AES_256_CTR_MODE_EN
  logic   ctr_load;
  block_t ctr_seed;

  modport master (
    output key_ready, rk_data, in_valid, in_block, out_ready, ctr_load, ctr_seed,
    input  rk_idx, in_ready, out_valid, out_block, busy
  );
  modport slave (
    input  key_ready, rk_data, in_valid, in_block, out_ready, ctr_load, ctr_seed,
    output rk_idx, in_ready, out_valid, out_block, busy
  );
`else
  modport master (
    output key_ready, rk_data, in_valid, in_block, out_ready,
    input  rk_idx, in_ready, out_valid, out_block, busy
  );
  modport slave (
    input  key_ready, rk_data, in_valid, in_block, out_ready,
    output rk_idx, in_ready, out_valid, out_block, busy
  );
`endif
endinterface

// File: rtl/AES_256_roundop.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on LAST_RND), AddRoundKey.
// Zero latency; no flow control of its own.
module AES_256_roundop
  import aes_pkg::*;
#(
  parameter int LAST_RND = AES256_LAST_RND
) (
  input  block_t input_text,
  input  block_t round_key,
  input  rkidx_t round,
  output block_t output_text
);

  logic [7:0] w_sub [16];
  logic [7:0] w_shf [16];
  logic [7:0] w_mix [16];
  block_t     w_pre_key;
  logic       w_final;

  assign w_final = (round == rkidx_t'(LAST_RND));

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_sub[i] = aes_sbox(input_text[127-8*i -: 8]);
    end
  end

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_shf[4*c+r] = w_sub[4*((c+r)%4)+r];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_mix[4*c+r] = gf_xtime(w_shf[4*c+r]) ^ gf_xtime(w_shf[4*c+(r+1)%4]) ^
                       w_shf[4*c+(r+1)%4] ^ w_shf[4*c+(r+2)%4] ^ w_shf[4*c+(r+3)%4];
      end
    end
  end

  always_comb begin
    w_pre_key = '0;
    for (int i = 0; i < 16; i++) begin
      w_pre_key[127-8*i -: 8] = w_final ? w_shf[i] : w_mix[i];
    end
  end

  assign output_text = w_pre_key ^ round_key;

endmodule

// File: rtl/aes_256_round_ctrl.sv
// Iterative AES-256 controller, one round per clock; optional CTR keystream via AES_256_CTR_MODE_EN.
// Latency 14 cycles accept->out_valid, period 16; result held in DONE while out_ready is low.
module aes_256_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES256_NR
) (
  input logic                 clk,
  input logic                 rst_n,
  aes_256_round_ctrl_if.slave bus
);

  fsm_state_t r_fsm;
  fsm_state_t w_fsm_nxt;
  block_t     r_state;
  rkidx_t     r_rnd;
  logic       r_rst_done;

  block_t     w_cipher_in;
  block_t     w_rnd_out;
  block_t     w_out_block;
  rkidx_t     w_rk_idx;
  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_busy;
  logic       w_accept;
  logic       w_last;
  logic       w_load;

`ifdef AES_256_CTR_MODE_EN
  block_t r_ctr;
  block_t r_dat;

  assign w_load      = bus.ctr_load;
  assign w_cipher_in = r_ctr;
  assign w_out_block = r_state ^ r_dat;
`else
  assign w_load      = 1'b0;
  assign w_cipher_in = bus.in_block;
  assign w_out_block = r_state;
`endif

  assign w_last   = (r_rnd == rkidx_t'(NR - 1));
  assign w_accept = w_in_ready & bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= ST_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // r_rst_done keeps in_ready low until the first edge after reset release.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_rk_idx    = '0;
    w_busy      = 1'b1;
    case (r_fsm)
      ST_IDLE: begin
        w_busy     = 1'b0;
        w_in_ready = r_rst_done & bus.key_ready & ~w_load;
        if (w_in_ready && bus.in_valid) w_fsm_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_rk_idx = r_rnd + 4'd1;
        if (w_last) w_fsm_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_fsm_nxt = ST_IDLE;
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= '0;
      r_rnd      <= '0;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_accept) begin
        r_state <= w_cipher_in ^ bus.rk_data;
        r_rnd   <= '0;
      end else if (r_fsm == ST_RUN) begin
        r_state <= w_rnd_out;
        if (!w_last) r_rnd <= r_rnd + 4'd1;
      end
    end
  end

`ifdef AES_256_CTR_MODE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctr <= '0;
      r_dat <= '0;
    end else if (w_accept) begin
      r_dat <= bus.in_block;
      r_ctr <= r_ctr + 128'd1;
    end else if (r_fsm == ST_IDLE && w_load) begin
      r_ctr <= bus.ctr_seed;
    end
  end
`endif

  AES_256_roundop #(
    .LAST_RND (NR - 1)
  ) u_roundop (
    .input_text  (r_state),
    .round_key   (bus.rk_data),
    .round       (r_rnd),
    .output_text (w_rnd_out)
  );

  assign bus.rk_idx    = w_rk_idx;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.out_block = w_out_valid ? w_out_block : '0;

endmodule

// File: tb/tb_aes_256_round_ctrl.sv
// Bench for aes_256_round_ctrl: FIPS-197 C.3 vectors, a byte-level reference cipher and flow-control sequences.
module tb_aes_256_round_ctrl;
  import aes_pkg::*;

  localparam block_t       KAT_PT = 128'h00112233445566778899aabbccddeeff;
  localparam block_t       KAT_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
`ifdef AES_256_CTR_MODE_EN
  localparam block_t       KAT_IN = '0;
`else
  localparam block_t       KAT_IN = KAT_PT;
`endif

  typedef struct {
    block_t in;
    block_t exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  aes_256_round_ctrl_if bus();

  aes_256_round_ctrl #(.NR(AES256_NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] sb [256];
  block_t     rk [15];
  block_t     m_ctr;
  int         n_tests = 0;
  int         n_fail  = 0;

  always_comb bus.rk_data = (bus.rk_idx <= 4'd14) ? rk[bus.rk_idx] : '0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mulc(input int c, input logic [7:0] a);
    if (c == 1) return a;
    if (c == 2) return mul2(a);
    return mul2(a) ^ a;
  endfunction

  // S-box from walking the multiplicative group with generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic build_keys();
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [255:0] key_v;
    key_v = KEY;
    for (int i = 0; i < 8; i++) w[i] = key_v[255-32*i -: 32];
    rcon = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t    = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = mul2(rcon);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic block_t ref_enc(input block_t pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    int         circ [4];
    block_t     b;
    circ = '{2, 3, 1, 1};
    b = pt ^ rk[0];
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[b[127-8*i -: 8]];
      for (int i = 0; i < 16; i++) t[i] = s[(i + 4*(i%4)) % 16];
      for (int c = 0; c < 4; c++) begin
        for (int row = 0; row < 4; row++) begin
          if (r == 14) begin
            s[4*c+row] = t[4*c+row];
          end else begin
            s[4*c+row] = 8'h00;
            for (int k = 0; k < 4; k++) s[4*c+row] = s[4*c+row] ^ mulc(circ[(k-row+4)%4], t[4*c+k]);
          end
        end
      end
      for (int i = 0; i < 16; i++) b[127-8*i -: 8] = s[i];
      b = b ^ rk[r];
    end
    return b;
  endfunction

  task automatic expect_for(input block_t d, output block_t e);
`ifdef AES_256_CTR_MODE_EN
    e     = ref_enc(m_ctr) ^ d;
    m_ctr = m_ctr + 128'd1;
`else
    e = ref_enc(d);
`endif
  endtask

  task automatic kat_prep();
`ifdef AES_256_CTR_MODE_EN
    @(negedge clk);
    bus.ctr_load = 1'b1;
    bus.ctr_seed = KAT_PT;
    #1;
    chk("load_blocks_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    bus.ctr_load = 1'b0;
    m_ctr = KAT_PT;
`endif
  endtask

  // Caller sits between a negedge and the following posedge.
  task automatic run_block(input block_t blk, input block_t exp, input string tag, input int hold);
    int n;
    int lat;
    bus.in_valid  = 1'b1;
    bus.in_block  = blk;
    bus.out_ready = 1'b0;
    #1;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_accept"}, bus.in_ready, 1'b1);
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 14);
    chk({tag, "_data"}, bus.out_block, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {bus.out_valid, bus.in_ready, bus.busy, bus.out_block}, {1'b1, 1'b0, 1'b1, exp});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk({tag, "_idle_after"}, {bus.busy, bus.out_valid}, 2'b00);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t   vec [6];
    block_t e, d1, d2, s, ones, zero;
    block_t exp_q [$];
    int     acc_t [$];
    int     cyc, n_out;

    bus.key_ready = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_block  = '0;
    bus.out_ready = 1'b0;
`ifdef AES_256_CTR_MODE_EN
    bus.ctr_load  = 1'b0;
    bus.ctr_seed  = '0;
`endif
    build_sbox();
    build_keys();
    m_ctr = '0;

    #1 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {bus.out_valid, bus.in_ready, bus.busy, bus.rk_idx, bus.out_block}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_first_edge", bus.in_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("in_ready_after_first_edge", bus.in_ready, 1'b1);

    // Vector table: entry 0 is the FIPS-197 known answer, the rest are random.
    kat_prep();
    for (int i = 0; i < 6; i++) begin
      vec[i].in = (i == 0) ? KAT_IN : {$urandom, $urandom, $urandom, $urandom};
      expect_for(vec[i].in, e);
      vec[i].exp = (i == 0) ? KAT_CT : e;
    end
    for (int i = 0; i < 6; i++) run_block(vec[i].in, vec[i].exp, $sformatf("vec%0d", i), 0);

    kat_prep();
    run_block(KAT_IN, KAT_CT, "backpressure", 10);

    // Back-to-back with in_valid and out_ready held high.
    kat_prep();
    @(negedge clk);
    bus.in_block  = KAT_IN;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cyc   = 0;
    n_out = 0;
    while (n_out < 4 && cyc < 200) begin
      #1;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("b2b_spurious_out", bus.out_valid, 1'b0);
        else chk("b2b_data", bus.out_block, exp_q.pop_front());
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        expect_for(bus.in_block, e);
        exp_q.push_back(e);
        acc_t.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
      if (acc_t.size() >= 4) bus.in_valid = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_outputs", n_out, 4);
    chk("b2b_accepts", acc_t.size(), 4);
    for (int k = 1; k < acc_t.size(); k++) chk("b2b_spacing", acc_t[k] - acc_t[k-1], 16);

    // Asynchronous reset at round 7 of an in-flight block.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_block = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("mid_accept", bus.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    chk("mid_round7", {bus.busy, bus.rk_idx}, {1'b1, 4'd8});
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_async", {bus.out_valid, bus.in_ready, bus.busy, bus.rk_idx, bus.out_block}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ctr = '0;
    kat_prep();
    run_block(KAT_IN, KAT_CT, "post_reset", 0);

`ifdef AES_256_CTR_MODE_EN
    ones = '1;
    zero = '0;
    d1   = {$urandom, $urandom, $urandom, $urandom};
    d2   = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus.ctr_load = 1'b1;
    bus.ctr_seed = ones;
    @(negedge clk);
    bus.ctr_load = 1'b0;
    run_block(d1, ref_enc(ones) ^ d1, "ctr_allones", 0);
    run_block(d2, ref_enc(zero) ^ d2, "ctr_wrap", 0);

    s  = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus.ctr_load = 1'b1;
    bus.ctr_seed = s;
    bus.in_valid = 1'b1;
    bus.in_block = d1;
    #1;
    chk("col_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    bus.ctr_load = 1'b0;
    #1;
    chk("col_no_accept", {bus.busy, bus.in_ready}, 2'b01);
    run_block(d1, ref_enc(s) ^ d1, "ctr_collision", 0);
`else
    ones = '0;
    zero = '0;
    d1   = '0;
    d2   = '0;
    s    = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/aes_256_round_ctrl.md
# aes_256_round_ctrl

Iterative AES-256 encryption controller. It sequences one `AES_256_roundop` instance through the 14 cipher rounds, one round per clock. It fetches round keys by index from the key-expansion storage and presents ciphertext (or CTR keystream-XORed data) through valid/ready handshakes. It sits between the CTR front end and the round datapath and is the only driver of the datapath's `input_text`, `round_key` and `round` inputs.

## Interface
- `NR`, default 14: number of round-op iterations; fixed for AES-256; the final-round index is `NR-1`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `key_ready`, input, 1: the key schedule is fully expanded and stable.
- `rk_idx`, output, 4: round-key index, 0..14. Key storage returns the key combinationally in the same cycle.
- `rk_data`, input, 128: round key selected by `rk_idx`.
- `in_valid`, input, 1: `in_block` is valid.
- `in_ready`, output, 1: the controller accepts a block this cycle.
- `in_block`, input, 128: plaintext, or the data block in CTR mode. Bits [127:120] are byte 0.
- `out_valid`, output, 1: `out_block` is valid.
- `out_ready`, input, 1: the consumer accepts `out_block`.
- `out_block`, output, 128: result block.
- `busy`, output, 1: the FSM is not in IDLE.
- `ctr_load`, input, 1: CTR seed load request (present only with `AES_256_CTR_MODE_EN`).
- `ctr_seed`, input, 128: initial counter value (present only with `AES_256_CTR_MODE_EN`).

## Operation
- FSM states:
  - IDLE, reset state.
  - RUN.
  - DONE.
- IDLE:
  - `rk_idx`=0.
  - `in_ready` = `key_ready` & ~`ctr_load`.
  - On accept (`in_valid`&`in_ready`): `state_q` <= cipher input ^ `rk_data`, which is the initial AddRoundKey with key 0. Then `rnd_q` <= 0 and the FSM goes to RUN.
- RUN:
  - Datapath inputs: `input_text`=`state_q`, `round`=`rnd_q`, `round_key`=`rk_data`, `rk_idx`=`rnd_q`+1.
  - Each cycle: `state_q` <= `output_text`.
  - If `rnd_q`==`NR-1` (13), go to DONE. The datapath skips MixColumns on index 13. Otherwise `rnd_q` increments.
- DONE:
  - `out_valid`=1 and `out_block`=`state_q` (in CTR mode, `state_q` ^ the data register).
  - On `out_ready`, go to IDLE.
  - `out_block` and `out_valid` are held stable until accepted.
- `rk_idx` in DONE is 0.
- `in_ready` is 0 in RUN and DONE. No block is accepted while one is in flight.
- `key_ready` dropping during RUN has no effect on the block in flight. Key storage must not change while `busy`=1.
- Reset, including mid-operation, is asynchronous and forces:
  - the FSM to IDLE;
  - `rnd_q`=0 and `state_q`=0;
  - the data register and counter to 0;
  - `out_valid`=0, `in_ready`=0 until the first edge after release, `busy`=0, `rk_idx`=0, `out_block`=0.
  - The in-flight block is discarded.

## Timing
- Accept edge E0.
- Round indices 0..13 are applied on edges E1..E14.
- `out_valid` is high after E14. Latency is 14 cycles from the accept edge to `out_valid`.
- With `out_ready` tied high, DONE lasts 1 cycle. The minimum block period is 16 cycles: IDLE, RUN×14, DONE.
- Back-pressure: DONE persists any number of cycles while `out_ready`=0.

## Configuration
- Macro: `AES_256_CTR_MODE_EN`.
- Defined:
  - A 128-bit counter `ctr_q` and a data register `dat_q` exist.
  - In IDLE, `ctr_load`=1 sets `ctr_q` <= `ctr_seed`. Load has priority: `in_ready`=0 that cycle.
  - On accept, the cipher input is `ctr_q` and `dat_q` <= `in_block`. `ctr_q` then increments modulo 2^128, so all-ones wraps to 0.
  - `out_block` = E(ctr) ^ `dat_q`.
- Undefined:
  - The cipher input is `in_block` and `out_block` = E(`in_block`).
  - The `ctr_load` and `ctr_seed` ports, `ctr_q` and `dat_q` are absent.

## Structure
- Shared package `aes_pkg` holds:
  - `block_t` (128-bit) and `rkidx_t` (4-bit);
  - constants `AES256_NR`=14 and `AES256_LAST_RND`=13;
  - the FSM state enum.
- One sub-module: `AES_256_roundop`, instantiated once. The controller owns all registers.

## Test plan
- FIPS-197 C.3 known-answer test:
  - Stimulus: key 000102…1f expanded into key storage, `in_block`=00112233445566778899aabbccddeeff.
  - Required: `out_block`=8ea2b7ca516745bfeafc49904b496089, with `out_valid` exactly 14 cycles after accept.
- Back-pressure:
  - Stimulus: hold `out_ready`=0 for 10 cycles in DONE.
  - Required: `out_block` stable, `in_ready`=0 and `busy`=1 throughout; IDLE follows the cycle after `out_ready`=1.
- Back-to-back:
  - Stimulus: `in_valid` and `out_ready` constantly high, 4 blocks.
  - Required: accepts occur 16 cycles apart and all 4 known-answer results match.
- Reset mid-operation:
  - Stimulus: deassert `rst_n` at round 7.
  - Required: all outputs 0 immediately without waiting for a clock edge; the next accepted block gives the correct known-answer result.
- CTR mode (`AES_256_CTR_MODE_EN`):
  - Stimulus: `ctr_seed`=ffff…ff, then 2 blocks.
  - Required: the second block uses counter 0 (wrap), and each output equals E(ctr) ^ data.
- CTR load/accept collision (`AES_256_CTR_MODE_EN`):
  - Stimulus: `ctr_load` and `in_valid` asserted together in IDLE.
  - Required: the load takes effect, no accept occurs, and the block is accepted in the next cycle with the new seed.
